// File: rtl/freq_sweep_if.sv
// Bundle of sweep configuration, control strobes and DDS-facing status
// outputs shared between the sweep controller and whoever drives it.
interface freq_sweep_if #(
  parameter int DWELL_W = 24
);
  // Sweep configuration, captured by the controller on an accepted go
  logic [31:0]        start_m;
  logic [31:0]        stop_m;
  logic [31:0]        step_m;
  logic [DWELL_W-1:0] dwell;
  logic               cont;

  // Single-cycle control requests
  logic               go;
  logic               abort;

  // Registered outputs towards the DDS stage and the host
  logic [31:0]        m;
  logic               set;
  logic               en;
  logic               busy;
  logic               done;
  logic               err;

  // Host side: drives configuration and requests, observes status
  modport master (
    output start_m, stop_m, step_m, dwell, cont, go, abort,
    input  m, set, en, busy, done, err
  );

  // Controller side: consumes configuration, produces status
  modport slave (
    input  start_m, stop_m, step_m, dwell, cont, go, abort,
    output m, set, en, busy, done, err
  );
endinterface

// File: rtl/freq_sweep.sv
// Frequency sweep controller: steps a DDS tuning word from start to stop in
// fixed increments, holding each word for a programmable number of cycles,
// either once or continuously until aborted.
module freq_sweep #(
  parameter int DWELL_W = 24
) (
  input logic        clk,
  input logic        rst,
  freq_sweep_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    DONE
  } state_e;

  state_e             state_q, state_d;

  // Shadow copies of the configuration, frozen for the whole sweep
  logic [31:0]        startShadow_q, startShadow_d;
  logic [31:0]        stopShadow_q, stopShadow_d;
  logic [31:0]        stepShadow_q, stepShadow_d;
  logic [DWELL_W-1:0] dwellShadow_q, dwellShadow_d;
  logic               contShadow_q, contShadow_d;

  // Remaining hold cycles for the current tuning word
  logic [DWELL_W-1:0] dwellCnt_q, dwellCnt_d;

  // Registered outputs
  logic [31:0]        m_q, m_d;
  logic               set_q, set_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // 33-bit sum so that a step carrying past 2^32 is seen as beyond stop
  // instead of wrapping back to a small tuning word.
  logic [32:0]        nextSum;
  logic               goValid;

  assign nextSum = {1'b0, m_q} + {1'b0, stepShadow_q};
  assign goValid = (bus.step_m != 32'd0) && (bus.start_m <= bus.stop_m);

  // State, shadow, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      startShadow_q <= '0;
      stopShadow_q  <= '0;
      stepShadow_q  <= '0;
      dwellShadow_q <= '0;
      contShadow_q  <= 1'b0;
      dwellCnt_q    <= '0;
      m_q           <= '0;
      set_q         <= 1'b0;
      en_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      startShadow_q <= startShadow_d;
      stopShadow_q  <= stopShadow_d;
      stepShadow_q  <= stepShadow_d;
      dwellShadow_q <= dwellShadow_d;
      contShadow_q  <= contShadow_d;
      dwellCnt_q    <= dwellCnt_d;
      m_q           <= m_d;
      set_q         <= set_d;
      en_q          <= en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  // Next-state and next-output logic; strobes default low, levels hold
  always_comb begin
    state_d       = state_q;
    startShadow_d = startShadow_q;
    stopShadow_d  = stopShadow_q;
    stepShadow_d  = stepShadow_q;
    dwellShadow_d = dwellShadow_q;
    contShadow_d  = contShadow_q;
    dwellCnt_d    = dwellCnt_q;
    m_d           = m_q;
    set_d         = 1'b0;
    en_d          = en_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        // abort in the same cycle drops go silently, even an invalid one
        if (bus.go && !bus.abort) begin
          if (goValid) begin
            startShadow_d = bus.start_m;
            stopShadow_d  = bus.stop_m;
            stepShadow_d  = bus.step_m;
            dwellShadow_d = bus.dwell;
            contShadow_d  = bus.cont;
            dwellCnt_d    = bus.dwell;
            m_d           = bus.start_m;
            set_d         = 1'b1;
            en_d          = 1'b1;
            busy_d        = 1'b1;
            state_d       = DWELL;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      DWELL: begin
        if (bus.abort) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (dwellCnt_q != '0) begin
          dwellCnt_d = dwellCnt_q - 1'b1;
        end else if (nextSum <= {1'b0, stopShadow_q}) begin
          m_d        = nextSum[31:0];
          set_d      = 1'b1;
          dwellCnt_d = dwellShadow_q;
        end else if (contShadow_q) begin
          m_d        = startShadow_q;
          set_d      = 1'b1;
          dwellCnt_d = dwellShadow_q;
        end else begin
          done_d  = 1'b1;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.m    = m_q;
  assign bus.set  = set_q;
  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_freq_sweep.sv
// Self-checking bench for freq_sweep: expected output streams are built from
// the list of tuning words a sweep should visit, each held dwell+1 cycles.
module tb_freq_sweep;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  freq_sweep_if #(.DWELL_W(24)) bus ();

  freq_sweep #(.DWELL_W(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed output bundle {m, set, en, busy, done, err}
  function automatic logic [36:0] observed();
    return {bus.m, bus.set, bus.en, bus.busy, bus.done, bus.err};
  endfunction

  task automatic idle_inputs();
    bus.go    = 1'b0;
    bus.abort = 1'b0;
  endtask

  // Reset with go and abort also active: reset must dominate
  task automatic test_reset();
    logic [36:0] obs;
    rst         = 1'b1;
    bus.start_m = 32'd100;
    bus.stop_m  = 32'd130;
    bus.step_m  = 32'd10;
    bus.dwell   = 24'd2;
    bus.cont    = 1'b0;
    bus.go      = 1'b1;
    bus.abort   = 1'b1;
    tick();
    tick();
    obs = observed();
    checks++;
    if (obs !== 37'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: got=%h want=%h", obs, 37'd0);
    end
    idle_inputs();
    rst = 1'b0;
    tick();
    obs = observed();
    checks++;
    if (obs !== 37'd0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: got=%h want=%h", obs, 37'd0);
    end
  endtask

  // Run one sweep and compare every cycle against the word list model.
  // laps > 1 only makes sense with c = 1; a continuous run ends by abort.
  task automatic run_sweep(input logic [31:0] s, input logic [31:0] e,
                           input logic [31:0] st, input int dw, input bit c,
                           input int laps, input bit perturb,
                           input string name);
    longint      words[$];
    longint      w;
    logic [31:0] lastWord;
    logic [36:0] obs;
    logic [36:0] exp;
    int          cyc;

    words.delete();
    w = longint'(s);
    while (w <= longint'(e)) begin
      words.push_back(w);
      w = w + longint'(st);
    end
    lastWord = words[words.size()-1][31:0];

    bus.start_m = s;
    bus.stop_m  = e;
    bus.step_m  = st;
    bus.dwell   = dw[23:0];
    bus.cont    = c;
    bus.abort   = 1'b0;
    bus.go      = 1'b1;
    tick();
    bus.go = 1'b0;

    cyc = 0;
    for (int lap = 0; lap < laps; lap++) begin
      foreach (words[i]) begin
        for (int k = 0; k <= dw; k++) begin
          exp = {words[i][31:0], (k == 0), 1'b1, 1'b1, 1'b0, 1'b0};
          obs = observed();
          checks++;
          if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got=%h want=%h", name, cyc, obs, exp);
          end
          if (perturb) begin
            bus.start_m = $urandom;
            bus.stop_m  = $urandom;
            bus.step_m  = $urandom;
            bus.dwell   = 24'($urandom_range(0, 5));
            bus.cont    = 1'($urandom);
            bus.go      = 1'($urandom);
          end
          tick();
          cyc++;
        end
      end
    end
    bus.go = 1'b0;

    if (!c) begin
      exp = {lastWord, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      obs = observed();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL %s done_pulse: got=%h want=%h", name, obs, exp);
      end
      tick();
      exp = {lastWord, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      obs = observed();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL %s after_done: got=%h want=%h", name, obs, exp);
      end
    end else begin
      exp = {s, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      obs = observed();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL %s lap_wrap: got=%h want=%h", name, obs, exp);
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      exp = {s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      obs = observed();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL %s abort: got=%h want=%h", name, obs, exp);
      end
      tick();
      obs = observed();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL %s after_abort: got=%h want=%h", name, obs, exp);
      end
    end
  endtask

  task automatic test_single_sweep();
    run_sweep(32'd100, 32'd130, 32'd10, 2, 1'b0, 1, 1'b0, "single_sweep");
    run_sweep(32'd500, 32'd500, 32'd7, 1, 1'b0, 1, 1'b0, "one_point");
  endtask

  task automatic test_continuous();
    run_sweep(32'd100, 32'd130, 32'd10, 2, 1'b1, 3, 1'b0, "continuous");
  endtask

  task automatic test_overflow();
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 0, 1'b0, 1, 1'b0, "overflow");
    run_sweep(32'hFFFF_FFE0, 32'hFFFF_FFFF, 32'h9, 1, 1'b0, 1, 1'b0, "near_top");
  endtask

  task automatic test_mid_change();
    run_sweep(32'd100, 32'd130, 32'd10, 2, 1'b0, 1, 1'b1, "mid_change");
  endtask

  // Invalid go must pulse err and leave m and busy untouched
  task automatic test_reject();
    logic [31:0] mBefore;
    logic [36:0] obs;
    logic [36:0] exp;
    logic [31:0] sTab [2] = '{32'd100, 32'd200};
    logic [31:0] eTab [2] = '{32'd130, 32'd100};
    logic [31:0] pTab [2] = '{32'd0,   32'd10};
    for (int i = 0; i < 2; i++) begin
      mBefore     = bus.m;
      bus.start_m = sTab[i];
      bus.stop_m  = eTab[i];
      bus.step_m  = pTab[i];
      bus.dwell   = 24'd1;
      bus.cont    = 1'b0;
      bus.go      = 1'b1;
      tick();
      bus.go = 1'b0;
      exp = {mBefore, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      obs = observed();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL reject_%0d err_pulse: got=%h want=%h", i, obs, exp);
      end
      tick();
      exp = {mBefore, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      obs = observed();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL reject_%0d settle: got=%h want=%h", i, obs, exp);
      end
    end
  endtask

  // go together with abort in IDLE is dropped, valid or not
  task automatic test_abort_go();
    logic [31:0] mBefore;
    logic [36:0] obs;
    logic [36:0] exp;
    for (int i = 0; i < 2; i++) begin
      mBefore     = bus.m;
      bus.start_m = 32'd40;
      bus.stop_m  = 32'd80;
      bus.step_m  = (i == 0) ? 32'd5 : 32'd0;
      bus.dwell   = 24'd0;
      bus.cont    = 1'b0;
      bus.go      = 1'b1;
      bus.abort   = 1'b1;
      tick();
      idle_inputs();
      exp = {mBefore, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      obs = observed();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL abort_go_%0d: got=%h want=%h", i, obs, exp);
      end
    end
  endtask

  // Reset mid-sweep, then reset together with go
  task automatic test_rst_mid();
    logic [36:0] obs;
    bus.start_m = 32'd100;
    bus.stop_m  = 32'd130;
    bus.step_m  = 32'd10;
    bus.dwell   = 24'd2;
    bus.cont    = 1'b1;
    bus.go      = 1'b1;
    tick();
    bus.go = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    obs = observed();
    checks++;
    if (obs !== 37'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_sweep: got=%h want=%h", obs, 37'd0);
    end
    bus.go = 1'b1;
    tick();
    rst    = 1'b0;
    bus.go = 1'b0;
    obs = observed();
    checks++;
    if (obs !== 37'd0) begin
      errors++;
      $display("[TB] FAIL rst_with_go: got=%h want=%h", obs, 37'd0);
    end
    tick();
    obs = observed();
    checks++;
    if (obs !== 37'd0) begin
      errors++;
      $display("[TB] FAIL rst_go_no_start: got=%h want=%h", obs, 37'd0);
    end
  endtask

  // Randomised single sweeps, some placed near the top of the word range
  task automatic test_random();
    logic [31:0] s;
    logic [31:0] e;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) == 0) s = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      else                           s = $urandom;
      r = 32'($urandom_range(0, 200));
      if (s > 32'hFFFF_FFFF - r) e = 32'hFFFF_FFFF;
      else                       e = s + r;
      run_sweep(s, e, 32'($urandom_range(1, 80)), $urandom_range(0, 3),
                1'b0, 1, 1'b0, $sformatf("random_%0d", i));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_single_sweep();
    test_continuous();
    test_reject();
    test_overflow();
    test_mid_change();
    test_abort_go();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
